// File: rtl/move_checker.sv
// Validates one chess move by walking the squares it crosses through a board read port.
// Define MOVE_CHECKER_KING_CAPTURE_BLOCK_EN to make any destination holding a king invalid.
module move_checker #(
    parameter int COORD_W  = 3,
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_validation,
    input  logic               current_player,
    input  logic [3:0]         piece_to_move,
    input  logic [COORD_W-1:0] origin_x,
    input  logic [COORD_W-1:0] origin_y,
    input  logic [COORD_W-1:0] destination_x,
    input  logic [COORD_W-1:0] destination_y,
    input  logic [3:0]         piece_read,
    output logic [COORD_W-1:0] address_x,
    output logic [COORD_W-1:0] address_y,
    output logic               move_valid,
    output logic               validate_complete,
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, GEOM, ADDR, WAIT, EVAL, DONE} state_t;

    localparam logic [COORD_W:0]          D1         = (COORD_W+1)'(1);
    localparam logic [COORD_W:0]          D2         = (COORD_W+1)'(2);
    localparam logic signed [COORD_W:0]   FWD1       = (COORD_W+1)'(1);
    localparam logic signed [COORD_W:0]   FWD2       = (COORD_W+1)'(2);
    localparam logic [COORD_W-1:0]        C1         = COORD_W'(1);
    localparam logic [COORD_W-1:0]        C2         = COORD_W'(2);
    localparam logic [COORD_W-1:0]        WHITE_HOME = COORD_W'(1);
    localparam logic [COORD_W-1:0]        BLACK_HOME = COORD_W'((1 << COORD_W) - 2);
    localparam logic [1:0]                WAIT_LAST  = 2'(READ_LAT - 2);

    state_t             state_q;
    logic               player_q;
    logic [3:0]         piece_q;
    logic [COORD_W-1:0] originX_q, originY_q, destX_q, destY_q;
    logic [COORD_W-1:0] addrX_q, addrY_q;
    logic [COORD_W-1:0] remaining_q;
    logic [1:0]         waitCnt_q;
    logic               needEmpty_q, needEnemy_q;
    logic               result_q, valid_q, complete_q, busy_q;

    logic signed [COORD_W:0] deltaX_d, deltaY_d, forward_d;
    logic [COORD_W:0]        absX_d, absY_d, maxAbs_d;
    logic [COORD_W-1:0]      stepX_d, stepY_d, pathLen_d, homeY_d;
    logic [3:0]              kind_d;
    logic                    colour_d, legalCode_d, samePos_d;
    logic                    rookLike_d, bishopLike_d, knight_d, king_d;
    logic                    pawnStraight_d, pawnDouble_d, pawnDiag_d, isPawn_d;
    logic                    geomOk_d;
    logic                    readEmpty_d, readEnemy_d, kingBlock_d, destOk_d;

    // Geometry is evaluated from the latched request, so it is stable throughout GEOM.
    always_comb begin
        deltaX_d     = $signed({1'b0, destX_q}) - $signed({1'b0, originX_q});
        deltaY_d     = $signed({1'b0, destY_q}) - $signed({1'b0, originY_q});
        absX_d       = deltaX_d[COORD_W] ? $unsigned(-deltaX_d) : $unsigned(deltaX_d);
        absY_d       = deltaY_d[COORD_W] ? $unsigned(-deltaY_d) : $unsigned(deltaY_d);
        maxAbs_d     = (absX_d > absY_d) ? absX_d : absY_d;
        stepX_d      = (absX_d == '0) ? '0 : (deltaX_d[COORD_W] ? '1 : C1);
        stepY_d      = (absY_d == '0) ? '0 : (deltaY_d[COORD_W] ? '1 : C1);
        colour_d     = (piece_q >= 4'd7);
        kind_d       = colour_d ? piece_q - 4'd6 : piece_q;
        legalCode_d  = (piece_q != 4'd0) && (piece_q <= 4'd12);
        samePos_d    = (absX_d == '0) && (absY_d == '0);
        forward_d    = colour_d ? -deltaY_d : deltaY_d;
        homeY_d      = colour_d ? BLACK_HOME : WHITE_HOME;

        rookLike_d     = (absX_d == '0) ^ (absY_d == '0);
        bishopLike_d   = (absX_d == absY_d) && (absX_d != '0);
        knight_d       = ((absX_d == D1) && (absY_d == D2)) || ((absX_d == D2) && (absY_d == D1));
        king_d         = (maxAbs_d == D1);
        pawnStraight_d = (absX_d == '0) && (forward_d == FWD1);
        pawnDouble_d   = (absX_d == '0) && (forward_d == FWD2) && (originY_q == homeY_d);
        pawnDiag_d     = (absX_d == D1) && (forward_d == FWD1);
        isPawn_d       = (kind_d == 4'd1);

        geomOk_d  = 1'b0;
        pathLen_d = C1;
        case (kind_d)
            4'd1: begin
                geomOk_d  = pawnStraight_d || pawnDouble_d || pawnDiag_d;
                pathLen_d = pawnDouble_d ? C2 : C1;
            end
            4'd2: geomOk_d = knight_d;
            4'd3: begin
                geomOk_d  = bishopLike_d;
                pathLen_d = maxAbs_d[COORD_W-1:0];
            end
            4'd4: begin
                geomOk_d  = rookLike_d;
                pathLen_d = maxAbs_d[COORD_W-1:0];
            end
            4'd5: begin
                geomOk_d  = rookLike_d || bishopLike_d;
                pathLen_d = maxAbs_d[COORD_W-1:0];
            end
            4'd6: geomOk_d = king_d;
            default: geomOk_d = 1'b0;
        endcase
        geomOk_d = geomOk_d && legalCode_d && !samePos_d && (colour_d == player_q);
    end

    // Codes 13-15 read back from the board count as neither empty nor enemy.
    always_comb begin
        readEmpty_d = (piece_read == 4'd0);
        readEnemy_d = player_q ? ((piece_read >= 4'd1) && (piece_read <= 4'd6))
                               : ((piece_read >= 4'd7) && (piece_read <= 4'd12));
`ifdef MOVE_CHECKER_KING_CAPTURE_BLOCK_EN
        kingBlock_d = (piece_read == 4'd6) || (piece_read == 4'd12);
`else
        kingBlock_d = 1'b0;
`endif
        if (needEmpty_q)
            destOk_d = readEmpty_d;
        else if (needEnemy_q)
            destOk_d = readEnemy_d;
        else
            destOk_d = readEmpty_d || readEnemy_d;
        destOk_d = destOk_d && !kingBlock_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            player_q    <= 1'b0;
            piece_q     <= 4'd0;
            originX_q   <= '0;
            originY_q   <= '0;
            destX_q     <= '0;
            destY_q     <= '0;
            addrX_q     <= '0;
            addrY_q     <= '0;
            remaining_q <= '0;
            waitCnt_q   <= 2'd0;
            needEmpty_q <= 1'b0;
            needEnemy_q <= 1'b0;
            result_q    <= 1'b0;
            valid_q     <= 1'b0;
            complete_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_validation) begin
                        player_q  <= current_player;
                        piece_q   <= piece_to_move;
                        originX_q <= origin_x;
                        originY_q <= origin_y;
                        destX_q   <= destination_x;
                        destY_q   <= destination_y;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= GEOM;
                    end else if (complete_q) begin
                        busy_q <= 1'b0;
                    end
                end
                GEOM: begin
                    needEmpty_q <= isPawn_d && !pawnDiag_d;
                    needEnemy_q <= isPawn_d && pawnDiag_d;
                    if (geomOk_d) begin
                        addrX_q     <= (pathLen_d == C1) ? destX_q : originX_q + stepX_d;
                        addrY_q     <= (pathLen_d == C1) ? destY_q : originY_q + stepY_d;
                        remaining_q <= pathLen_d;
                        state_q     <= ADDR;
                    end else begin
                        result_q <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                ADDR: begin
                    waitCnt_q <= 2'd0;
                    state_q   <= (READ_LAT == 1) ? EVAL : WAIT;
                end
                WAIT: begin
                    waitCnt_q <= waitCnt_q + 2'd1;
                    if (waitCnt_q == WAIT_LAST)
                        state_q <= EVAL;
                end
                EVAL: begin
                    if (remaining_q == C1) begin
                        result_q <= destOk_d;
                        state_q  <= DONE;
                    end else if (!readEmpty_d) begin
                        result_q <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        addrX_q     <= addrX_q + stepX_d;
                        addrY_q     <= addrY_q + stepY_d;
                        remaining_q <= remaining_q - C1;
                        state_q     <= ADDR;
                    end
                end
                DONE: begin
                    complete_q <= 1'b1;
                    valid_q    <= result_q;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign address_x         = addrX_q;
    assign address_y         = addrY_q;
    assign move_valid        = valid_q;
    assign validate_complete = complete_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_move_checker.sv
// Scoreboard bench for move_checker: a latency-accurate board memory plus per-scenario move tables.
module tb_move_checker;

    localparam int CW       = 3;
    localparam int READ_LAT = 1;
`ifdef MOVE_CHECKER_KING_CAPTURE_BLOCK_EN
    localparam int KING_CAPTURE_OK = 0;
`else
    localparam int KING_CAPTURE_OK = 1;
`endif

    typedef struct {
        int piece, player, ox, oy, dx, dy, bx, by, bp, valid, lat;
    } move_t;

    typedef struct {
        logic valid;
        int   lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_validation;
    logic          current_player;
    logic [3:0]    piece_to_move;
    logic [CW-1:0] origin_x, origin_y, destination_x, destination_y;
    logic [3:0]    piece_read;
    logic [CW-1:0] address_x, address_y;
    logic          move_valid, validate_complete, busy;

    logic [3:0] board [8][8];
    logic [3:0] readPipe [READ_LAT];

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    logic gotValid;
    int   gotLat;
    bit   timedOut;
    logic busyAtStart;

    always #5 clk = ~clk;

    move_checker #(.COORD_W(CW), .READ_LAT(READ_LAT)) dut (
        .clk(clk),
        .reset(reset),
        .start_validation(start_validation),
        .current_player(current_player),
        .piece_to_move(piece_to_move),
        .origin_x(origin_x),
        .origin_y(origin_y),
        .destination_x(destination_x),
        .destination_y(destination_y),
        .piece_read(piece_read),
        .address_x(address_x),
        .address_y(address_y),
        .move_valid(move_valid),
        .validate_complete(validate_complete),
        .busy(busy)
    );

    // Board memory: data for the presented address appears READ_LAT cycles later.
    always @(posedge clk) begin
        readPipe[0] <= board[address_x][address_y];
        for (int i = 1; i < READ_LAT; i++)
            readPipe[i] <= readPipe[i-1];
    end
    assign piece_read = readPipe[READ_LAT-1];

    task automatic clearBoard();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                board[x][y] = 4'd0;
    endtask

    task automatic setupBoard(input move_t m);
        clearBoard();
        if (m.bp != 0)
            board[m.bx][m.by] = 4'(m.bp);
    endtask

    task automatic driveMove(input move_t m);
        piece_to_move    = 4'(m.piece);
        current_player   = 1'(m.player);
        origin_x         = CW'(m.ox);
        origin_y         = CW'(m.oy);
        destination_x    = CW'(m.dx);
        destination_y    = CW'(m.dy);
        start_validation = 1'b1;
    endtask

    task automatic scrambleInputs();
        start_validation = 1'b0;
        piece_to_move    = 4'($urandom_range(0, 15));
        current_player   = ~current_player;
        origin_x         = CW'($urandom_range(0, 7));
        origin_y         = CW'($urandom_range(0, 7));
        destination_x    = CW'($urandom_range(0, 7));
        destination_y    = CW'($urandom_range(0, 7));
    endtask

    task automatic waitComplete();
        gotLat   = 0;
        timedOut = 0;
        while (!validate_complete) begin
            if (gotLat >= 200) begin
                timedOut = 1;
                break;
            end
            @(posedge clk); #1;
            gotLat++;
        end
        gotValid = move_valid;
    endtask

    // Drives one request, changes every input right after acceptance, and waits for the pulse.
    task automatic applyStimulus(input move_t m);
        sb.push_back('{(m.valid != 0), m.lat});
        @(posedge clk); #1;
        driveMove(m);
        @(posedge clk); #1;
        busyAtStart = busy;
        scrambleInputs();
        waitComplete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (move_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset move_valid: got %b, expected 0", move_valid); end
        checks++; if (validate_complete !== 1'b0) begin fails++; $display("[TB] FAIL reset validate_complete: got %b, expected 0", validate_complete); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset busy: got %b, expected 0", busy); end
        checks++; if (address_x !== 3'd0 || address_y !== 3'd0) begin fails++; $display("[TB] FAIL reset address: got (%0d,%0d), expected (0,0)", address_x, address_y); end
        reset = 1'b1;
    endtask

    task automatic test_rook_walk();
        move_t m = '{4, 0, 0, 0, 0, 7, 0, 0, 0, 1, 16};
        exp_t  e;
        setupBoard(m);
        applyStimulus(m);
        e = sb.pop_front();
        checks++; if (busyAtStart !== 1'b1) begin fails++; $display("[TB] FAIL rook busy after start: got %b, expected 1", busyAtStart); end
        checks++; if (timedOut || gotLat != e.lat) begin fails++; $display("[TB] FAIL rook latency: got %0d, expected %0d", gotLat, e.lat); end
        checks++; if (gotValid !== e.valid) begin fails++; $display("[TB] FAIL rook move_valid: got %b, expected %b", gotValid, e.valid); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL rook busy at complete: got %b, expected 1", busy); end
        @(posedge clk); #1;
        checks++; if (address_x !== 3'd0 || address_y !== 3'd7) begin fails++; $display("[TB] FAIL rook address hold: got (%0d,%0d), expected (0,7)", address_x, address_y); end
        checks++; if (validate_complete !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL rook after pulse: complete %b busy %b, expected 0 0", validate_complete, busy); end
        checks++; if (move_valid !== 1'b1) begin fails++; $display("[TB] FAIL rook valid hold: got %b, expected 1", move_valid); end
    endtask

    task automatic test_sliding();
        move_t tbl [7] = '{
            '{4, 0, 0, 0, 0, 7, 0, 3, 7, 0, 8},
            '{5, 0, 0, 0, 7, 7, 0, 0, 0, 1, 16},
            '{10, 1, 7, 7, 7, 0, 0, 0, 0, 1, 16},
            '{3, 0, 2, 0, 5, 3, 4, 2, 1, 0, 6},
            '{4, 0, 0, 0, 3, 3, 0, 0, 0, 0, 2},
            '{4, 0, 0, 7, 7, 7, 7, 7, 7, 1, 16},
            '{4, 0, 0, 0, 5, 0, 5, 0, 2, 0, 12}
        };
        exp_t e;
        foreach (tbl[i]) begin
            setupBoard(tbl[i]);
            applyStimulus(tbl[i]);
            e = sb.pop_front();
            checks++; if (timedOut || gotLat != e.lat) begin fails++; $display("[TB] FAIL sliding[%0d] latency: got %0d, expected %0d", i, gotLat, e.lat); end
            checks++; if (gotValid !== e.valid) begin fails++; $display("[TB] FAIL sliding[%0d] move_valid: got %b, expected %b", i, gotValid, e.valid); end
        end
    endtask

    task automatic test_knight_king();
        move_t tbl [7] = '{
            '{2, 0, 1, 0, 2, 2, 2, 2, 7, 1, 4},
            '{2, 0, 1, 0, 2, 2, 2, 2, 1, 0, 4},
            '{2, 0, 7, 0, 0, 2, 0, 0, 0, 0, 2},
            '{2, 0, 1, 0, 1, 2, 0, 0, 0, 0, 2},
            '{6, 0, 4, 4, 5, 5, 5, 5, 10, 1, 4},
            '{6, 0, 4, 4, 6, 4, 0, 0, 0, 0, 2},
            '{8, 1, 1, 7, 2, 5, 0, 0, 0, 1, 4}
        };
        exp_t e;
        foreach (tbl[i]) begin
            setupBoard(tbl[i]);
            applyStimulus(tbl[i]);
            e = sb.pop_front();
            checks++; if (timedOut || gotLat != e.lat) begin fails++; $display("[TB] FAIL knight_king[%0d] latency: got %0d, expected %0d", i, gotLat, e.lat); end
            checks++; if (gotValid !== e.valid) begin fails++; $display("[TB] FAIL knight_king[%0d] move_valid: got %b, expected %b", i, gotValid, e.valid); end
        end
    endtask

    task automatic test_pawn();
        move_t tbl [11] = '{
            '{1, 0, 3, 1, 3, 3, 0, 0, 0, 1, 6},
            '{1, 0, 3, 1, 3, 3, 3, 2, 7, 0, 4},
            '{1, 0, 3, 2, 3, 4, 0, 0, 0, 0, 2},
            '{1, 0, 3, 1, 4, 2, 0, 0, 0, 0, 4},
            '{1, 0, 3, 1, 4, 2, 4, 2, 9, 1, 4},
            '{1, 0, 3, 1, 3, 2, 3, 2, 7, 0, 4},
            '{7, 1, 4, 6, 4, 4, 0, 0, 0, 1, 6},
            '{7, 1, 4, 6, 4, 7, 0, 0, 0, 0, 2},
            '{7, 1, 4, 6, 5, 5, 5, 5, 2, 1, 4},
            '{1, 0, 3, 1, 3, 4, 0, 0, 0, 0, 2},
            '{1, 0, 3, 1, 3, 3, 3, 3, 7, 0, 6}
        };
        exp_t e;
        foreach (tbl[i]) begin
            setupBoard(tbl[i]);
            applyStimulus(tbl[i]);
            e = sb.pop_front();
            checks++; if (timedOut || gotLat != e.lat) begin fails++; $display("[TB] FAIL pawn[%0d] latency: got %0d, expected %0d", i, gotLat, e.lat); end
            checks++; if (gotValid !== e.valid) begin fails++; $display("[TB] FAIL pawn[%0d] move_valid: got %b, expected %b", i, gotValid, e.valid); end
        end
    endtask

    task automatic test_illegal();
        move_t tbl [6] = '{
            '{11, 0, 0, 0, 3, 3, 0, 0, 0, 0, 2},
            '{4, 0, 2, 2, 2, 2, 0, 0, 0, 0, 2},
            '{13, 0, 0, 0, 0, 5, 0, 0, 0, 0, 2},
            '{0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 2},
            '{4, 1, 0, 0, 0, 5, 0, 0, 0, 0, 2},
            '{3, 0, 2, 0, 5, 3, 5, 3, 12, KING_CAPTURE_OK, 8}
        };
        exp_t e;
        foreach (tbl[i]) begin
            setupBoard(tbl[i]);
            applyStimulus(tbl[i]);
            e = sb.pop_front();
            checks++; if (timedOut || gotLat != e.lat) begin fails++; $display("[TB] FAIL illegal[%0d] latency: got %0d, expected %0d", i, gotLat, e.lat); end
            checks++; if (gotValid !== e.valid) begin fails++; $display("[TB] FAIL illegal[%0d] move_valid: got %b, expected %b", i, gotValid, e.valid); end
        end
    endtask

    task automatic test_back_to_back();
        move_t first  = '{2, 0, 1, 0, 2, 2, 2, 2, 7, 1, 4};
        move_t second = '{2, 0, 3, 0, 3, 2, 0, 0, 0, 0, 2};
        exp_t  e;
        setupBoard(first);
        applyStimulus(first);
        e = sb.pop_front();
        checks++; if (timedOut || gotLat != e.lat || gotValid !== e.valid) begin fails++; $display("[TB] FAIL b2b first: got lat %0d valid %b, expected lat %0d valid %b", gotLat, gotValid, e.lat, e.valid); end
        sb.push_back('{(second.valid != 0), second.lat});
        driveMove(second);
        @(posedge clk); #1;
        scrambleInputs();
        checks++; if (busy !== 1'b1 || move_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b accept: busy %b valid %b, expected 1 0", busy, move_valid); end
        waitComplete();
        e = sb.pop_front();
        checks++; if (timedOut || gotLat != e.lat || gotValid !== e.valid) begin fails++; $display("[TB] FAIL b2b second: got lat %0d valid %b, expected lat %0d valid %b", gotLat, gotValid, e.lat, e.valid); end
    endtask

    task automatic test_reset_abort();
        move_t m = '{4, 0, 0, 0, 0, 7, 0, 0, 0, 1, 16};
        move_t k = '{2, 0, 1, 0, 2, 2, 2, 2, 7, 1, 4};
        exp_t  e;
        bit    seenPulse = 0;
        setupBoard(m);
        @(posedge clk); #1;
        driveMove(m);
        @(posedge clk); #1;
        scrambleInputs();
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        checks++; if (busy !== 1'b0 || validate_complete !== 1'b0) begin fails++; $display("[TB] FAIL abort outputs: busy %b complete %b, expected 0 0", busy, validate_complete); end
        checks++; if (address_x !== 3'd0 || address_y !== 3'd0) begin fails++; $display("[TB] FAIL abort address: got (%0d,%0d), expected (0,0)", address_x, address_y); end
        repeat (25) begin
            @(posedge clk); #1;
            if (validate_complete) seenPulse = 1;
        end
        checks++; if (seenPulse) begin fails++; $display("[TB] FAIL abort pulse: got a validate_complete, expected none"); end
        setupBoard(k);
        applyStimulus(k);
        e = sb.pop_front();
        checks++; if (timedOut || gotLat != e.lat || gotValid !== e.valid) begin fails++; $display("[TB] FAIL abort recovery: got lat %0d valid %b, expected lat %0d valid %b", gotLat, gotValid, e.lat, e.valid); end
    endtask

    initial begin
        reset            = 1'b0;
        start_validation = 1'b0;
        current_player   = 1'b0;
        piece_to_move    = 4'd0;
        origin_x         = '0;
        origin_y         = '0;
        destination_x    = '0;
        destination_y    = '0;
        clearBoard();
        test_reset();
        test_rook_walk();
        test_sliding();
        test_knight_king();
        test_pawn();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
